key_schedule_ctrl: RTL



---
 rtl/aes_pkg.sv | 55 +++++
 rtl/key_expansion.sv | 31 +++
 rtl/key_schedule_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, round count, FSM states, S-box and rcon.
package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_e;

  // Forward S-box; element 0 is the most significant byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // count 0..9 selects the round constant for expansion rounds 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] count);
    logic [7:0] rc;
    case (count)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_expansion.sv
// One combinational AES-128 key expansion round: previous round key -> next.
module key_expansion
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  input  logic [3:0]       count,
  output logic [KEY_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, temp;
  logic [31:0] n0, n1, n2, n3;

  // RotWord, SubWord and rcon on the last word, then the chained XORs.
  always_comb begin
    w0   = key_in[127:96];
    w1   = key_in[95:64];
    w2   = key_in[63:32];
    w3   = key_in[31:0];
    rot  = {w3[23:0], w3[31:24]};
    sub  = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
            sub_byte(rot[15:8]),  sub_byte(rot[7:0])};
    temp = sub ^ {rcon(count), 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    key_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule sequencer: expands one round per clock into an
// 11-entry key bank, read through a registered random-access port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; bank holds last schedule (if keys_valid)
// EXPAND | one round key generated and written per cycle (rounds 1..10)
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_EXPAND = EXPAND;
  localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS);

  logic [0:0]       state;
  logic [3:0]       round_cnt;
  logic [KEY_W-1:0] work;
  logic             done_r;
  logic             valid_r;

  logic [KEY_W-1:0] bank [0:NUM_ROUNDS];

  logic [KEY_W-1:0] exp_out;
  logic [3:0]       exp_count;

  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [KEY_W-1:0] wr_data;
  logic [KEY_W-1:0] rd_mux;

  assign exp_count = round_cnt - 4'd1;

  key_expansion u_key_expansion (
    .key_in  (work),
    .count   (exp_count),
    .key_out (exp_out)
  );

  // Sequencer: accept start in IDLE, walk the round counter 1..10 in EXPAND.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      round_cnt <= 4'd0;
      done_r    <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_EXPAND;
            round_cnt <= 4'd1;
            valid_r   <= 1'b0;
          end
        end
        ST_EXPAND: begin
          if (round_cnt == LAST_RND) begin
            // Counter parks at the last round rather than running past it.
            state   <= ST_IDLE;
            done_r  <= 1'b1;
            valid_r <= 1'b1;
          end else begin
            round_cnt <= round_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Working register feeds the single time-multiplexed expansion round.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_IDLE && start) begin
        work <= key_in;
      end else if (state == ST_EXPAND) begin
        work <= exp_out;
      end
    end
  end

  // Bank write port: key_in to entry 0 on accept, round result during EXPAND.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = exp_out;
    if (!rst) begin
      if (state == ST_IDLE && start) begin
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = key_in;
      end else if (state == ST_EXPAND) begin
        wr_en   = 1'b1;
        wr_addr = round_cnt;
      end
    end
  end

  // Bank storage is deliberately not reset; keys_valid qualifies its contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (wr_en && wr_addr == 4'(i)) begin
        bank[i] <= wr_data;
      end
    end
  end

  // Read decode: indices beyond the last round read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rd_idx == 4'(i)) begin
        rd_mux = bank[i];
      end
    end
  end

  // Registered read port, independent of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key <= '0;
    end else begin
      rd_key <= rd_mux;
    end
  end

  assign busy       = (state == ST_EXPAND);
  assign done       = done_r;
  assign keys_valid = valid_r;

endmodule
